i2s_dac_transmitter: RTL
========================

I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width per channel in bits.
REQ-002 SHALL have parameter SLOT, default 32, BCLK periods per channel slot; legal range SLOT >= WIDTH+1.
REQ-003 SHALL have parameter BCLK_DIV, default 4, clk cycles per BCLK half-period; legal range BCLK_DIV >= 1.
REQ-004 SHALL have port: clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: en  input  1  transmitter enable.
REQ-007 SHALL have port: s_left  input  WIDTH  signed left sample.
REQ-008 SHALL have port: s_right  input  WIDTH  signed right sample.
REQ-009 SHALL have port: s_valid  input  1  sample pair valid.
REQ-010 SHALL have port: s_ready  output  1  holding register empty, can accept.
REQ-011 SHALL have port: i2s_bclk  output  1  bit clock to codec.
REQ-012 SHALL have port: i2s_lrck  output  1  word select; 0 = left, 1 = right.
REQ-013 SHALL have port: i2s_sdata  output  1  serial data, MSB first.
REQ-014 SHALL have port: underrun  output  1  one-clk pulse on frame start with no sample pending.

Function
REQ-015 SHALL accept a sample pair into a WIDTH*2 holding register on a clk edge with s_valid=1 and s_ready=1.
REQ-016 SHALL drive s_ready = NOT holding_full, registered state, no combinational path from s_valid.
REQ-017 SHALL generate i2s_bclk by toggling after every BCLK_DIV clk cycles while en=1; BCLK period = 2*BCLK_DIV clk.
REQ-018 SHALL keep a bit counter 0..2*SLOT-1, advanced on each BCLK falling edge, wrapping to 0.
REQ-019 SHALL update i2s_lrck, i2s_sdata and the bit counter only on the clk edge that makes i2s_bclk fall.
REQ-020 SHALL drive i2s_lrck = 0 for bit counter 0..SLOT-1 and 1 for SLOT..2*SLOT-1.
REQ-021 SHALL drive, at slot index k (bit counter mod SLOT), i2s_sdata = sample bit WIDTH-k for k = 1..WIDTH, else 0 (standard I2S one-BCLK delay).
REQ-022 SHALL, on the falling edge where the bit counter wraps to 0, transfer the holding register to the output shift registers and clear holding_full.
REQ-023 SHALL, at that frame start with holding empty, load zeros into both shift registers and pulse underrun for exactly one clk.
REQ-024 SHALL, in the clk cycle of a frame-start transfer, not accept new data (s_ready was 0); s_ready rises on the following clk.
REQ-025 SHALL, on en=0, force i2s_bclk, i2s_lrck, i2s_sdata, divider and bit counter to 0 on the next clk edge; holding register and s_ready unaffected.
REQ-026 SHALL, on en rising, restart at bit counter 0 with a frame-start transfer at the first BCLK falling edge.
REQ-027 SHALL give latency from accept to first MSB on i2s_sdata of at most one frame plus one BCLK period.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, underrun=0, counters=0, holding_full=0, shift registers=0.
REQ-029 SHALL drive s_ready=1 out of reset; reset mid-frame abandons the frame and discards the held sample.

Configuration
REQ-030 SHALL, with macro I2S_TX_UNDERRUN_CNT_EN defined, add output underrun_cnt (16 bits), incremented per underrun pulse, saturating at 16'hFFFF, reset to 0.
REQ-031 SHALL, without I2S_TX_UNDERRUN_CNT_EN, omit port underrun_cnt and its counter; all other behaviour identical.

Verification (WIDTH=16, SLOT=32, BCLK_DIV=2)
REQ-032 Reset asserted mid-frame -> all outputs 0 immediately, s_ready=1, underrun_cnt=0.
REQ-033 en=1, send L=16'hA5F0 R=16'h0F0F -> next frame: left slot index 1..16 = 1010010111110000, right slot = 0000111100001111, index 0 and 17..31 = 0.
REQ-034 Accept one pair -> s_ready=0 until frame-start transfer, s_ready=1 one clk later; second pair sent then appears in the following frame.
REQ-035 en=1, no s_valid for 3 frames -> i2s_sdata constant 0, exactly 3 underrun pulses, underrun_cnt=3 (macro defined).
REQ-036 en dropped at bit counter 40 -> i2s_bclk/i2s_lrck 0 next clk; en re-raised -> lrck=0 and frame restarts at bit 0 with held sample.
REQ-037 Check BCLK period = 4 clk and LRCK period = 256 clk in steady state.

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_transmitter
// Description : I2S stereo transmitter with a one-pair holding register and
//               a clk-divided bit clock. `define I2S_TX_UNDERRUN_CNT_EN adds
//               a saturating 16-bit underrun counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_transmitter #(
  parameter int WIDTH    = 16,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             i2s_bclk,
  output logic             i2s_lrck,
  output logic             i2s_sdata,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]      underrun_cnt,
`endif
  output logic             underrun
);

  localparam int            BW      = $clog2(2 * SLOT);
  localparam int            DW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_B  = BW'(SLOT);
  localparam logic [BW-1:0] WIDTH_B = BW'(WIDTH);

  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [BW-1:0]    slot_k;
  logic             bclk_q, bclk_d;
  logic             first_q, first_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             under_q, under_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;

  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    bit_d    = bit_q;
    first_d  = first_q;
    lrck_d   = lrck_q;
    sdata_d  = sdata_q;
    under_d  = 1'b0;
    full_d   = full_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    slot_k   = '0;

    if (s_valid && !full_q) begin
      full_d   = 1'b1;
      hold_l_d = s_left;
      hold_r_d = s_right;
    end

    if (!en) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      bit_d   = '0;
      first_d = 1'b1;
      lrck_d  = 1'b0;
      sdata_d = 1'b0;
    end else if (div_q != DIV_MAX) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        // First fall after enable/reset is always a frame start.
        first_d = 1'b0;
        bit_d   = (first_q || bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
        if (bit_d == '0) begin
          if (full_q) begin
            sh_l_d = hold_l_q;
            sh_r_d = hold_r_q;
            full_d = 1'b0;
          end else begin
            sh_l_d  = '0;
            sh_r_d  = '0;
            under_d = 1'b1;
          end
        end
        lrck_d  = (bit_d >= SLOT_B);
        slot_k  = lrck_d ? bit_d - SLOT_B : bit_d;
        sdata_d = 1'b0;
        if (slot_k != '0 && slot_k <= WIDTH_B) begin
          if (lrck_d) begin
            sdata_d = sh_r_d[WIDTH-1];
            sh_r_d  = sh_r_d << 1;
          end else begin
            sdata_d = sh_l_d[WIDTH-1];
            sh_l_d  = sh_l_d << 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bit_q    <= '0;
      first_q  <= 1'b1;
      lrck_q   <= 1'b0;
      sdata_q  <= 1'b0;
      under_q  <= 1'b0;
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bit_q    <= bit_d;
      first_q  <= first_d;
      lrck_q   <= lrck_d;
      sdata_q  <= sdata_d;
      under_q  <= under_d;
      full_q   <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ucnt_q <= '0;
    end else if (under_d && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign s_ready   = ~full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = under_q;

endmodule
`default_nettype wire
